// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM with byte write enables, read-first, and a fixed-latency read pipe.
// Flags out-of-window accesses (sticky) and counts accepted loads/stores.
module data_sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    input  logic        err_clear,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("data_sram_responder: READ_LAT must be 1..4");
    end

    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic                  rd_req;

    // 33-bit compare so the window size never overflows
    assign offset   = data_sram_addr - ADDR_BASE;
    assign in_range = {1'b0, offset} < (33'd4 << DEPTH_LOG2);
    assign idx      = offset[DEPTH_LOG2+1:2];
    assign rd_word  = in_range ? mem[idx] : 32'h0;
    assign rd_req   = data_sram_en && (data_sram_wen == 4'h0);

    always_ff @(posedge clk) begin
        if (data_sram_en && in_range && (data_sram_wen != 4'h0)) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    logic [READ_LAT-1:0] vld_pipe;
    logic [31:0]         data_pipe [READ_LAT];
    logic [READ_LAT-1:0] v_in;
    logic [31:0]         d_in [READ_LAT];

    always_comb begin
        v_in[0] = rd_req;
        d_in[0] = rd_word;
        for (int i = 1; i < READ_LAT; i++) begin
            v_in[i] = vld_pipe[i-1];
            d_in[i] = data_pipe[i-1];
        end
    end

    // Final stage only loads on a valid response so rdata holds between reads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LAT; i++) data_pipe[i] <= 32'h0;
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_pipe[i] <= v_in[i];
                if (i < READ_LAT - 1 || v_in[i]) data_pipe[i] <= d_in[i];
            end
        end
    end

    assign data_sram_rdata = data_pipe[READ_LAT-1];
    assign rdata_valid     = vld_pipe[READ_LAT-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err <= 1'b0;
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else begin
            if (data_sram_en && !in_range) addr_err <= 1'b1;
            else if (err_clear)            addr_err <= 1'b0;
            if (rd_req)                                     rd_count <= rd_count + 32'd1;
            if (data_sram_en && (data_sram_wen != 4'h0))    wr_count <= wr_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (latency 1/2/3, different windows) share one
// request bus and are checked against a queue-based reference model of the RAM and its responses.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        err_clear = 1'b0;
    logic [31:0] rd [3];
    logic        rv [3];
    logic        er [3];
    logic [31:0] rc [3];
    logic [31:0] wc [3];

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_BASE(32'h0), .DEPTH_LOG2(6), .READ_LAT(1)) u0 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[0]),
        .rdata_valid(rv[0]), .addr_err(er[0]), .err_clear(err_clear),
        .rd_count(rc[0]), .wr_count(wc[0]));
    data_sram_responder #(.ADDR_BASE(32'h0), .DEPTH_LOG2(4), .READ_LAT(2)) u1 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[1]),
        .rdata_valid(rv[1]), .addr_err(er[1]), .err_clear(err_clear),
        .rd_count(rc[1]), .wr_count(wc[1]));
    data_sram_responder #(.ADDR_BASE(32'h80), .DEPTH_LOG2(4), .READ_LAT(3)) u2 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[2]),
        .rdata_valid(rv[2]), .addr_err(er[2]), .err_clear(err_clear),
        .rd_count(rc[2]), .wr_count(wc[2]));

    localparam logic [31:0] BASE [3] = '{32'h0, 32'h0, 32'h80};
    localparam int          DL   [3] = '{6, 4, 4};
    localparam int          LAT  [3] = '{1, 2, 3};

    typedef struct { int due; logic [31:0] data; } resp_t;

    // reference model state
    logic [31:0] mm [3][64];
    resp_t       pq [3][$];
    logic [31:0] e_rdata [3];
    logic        e_vld [3];
    logic        e_err [3];
    logic [31:0] e_rd [3];
    logic [31:0] e_wr [3];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pq[k].delete();
            e_rdata[k] = 32'h0; e_vld[k] = 1'b0; e_err[k] = 1'b0;
            e_rd[k] = 32'h0; e_wr[k] = 32'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] off;
            logic        inr;
            int          idx;
            logic [31:0] old;
            off = addr - BASE[k];
            inr = {1'b0, off} < (33'd4 << DL[k]);
            idx = int'((off >> 2) & ((32'd1 << DL[k]) - 32'd1));
            old = inr ? mm[k][idx] : 32'h0;
            if (en) begin
                if (wen == 4'h0) begin
                    e_rd[k] = e_rd[k] + 32'd1;
                    pq[k].push_back('{cyc + LAT[k] - 1, old});
                end else begin
                    e_wr[k] = e_wr[k] + 32'd1;
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (wen[b]) mm[k][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            if (en && !inr)     e_err[k] = 1'b1;
            else if (err_clear) e_err[k] = 1'b0;
            e_vld[k] = 1'b0;
            if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
                e_vld[k]   = 1'b1;
                e_rdata[k] = pq[k][0].data;
                void'(pq[k].pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        cyc++;
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'h0, 32'h4, 32'h0);
        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #2 resetn = 1'b0;
        #1 model_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rd[k] !== 32'h0 || rv[k] !== 1'b0 || er[k] !== 1'b0 || rc[k] !== 32'h0 || wc[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state k=%0d rdata=%h vld=%b err=%b rc=%0d wc=%0d required all 0",
                         k, rd[k], rv[k], er[k], rc[k], wc[k]);
            end
        end
        step(); step();
        #3 resetn = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (rv[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_flush k=%0d n=%0d vld=%b required 0", k, n, rv[k]);
                end
            end
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 4'hf, 32'(i * 4), $urandom);
            step();
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (wc[k] !== 32'd64 || rc[k] !== 32'd0 || er[k] !== 1'b0) begin
                bad++;
                $display("FAIL init_counts k=%0d wc=%0d rc=%0d err=%b required 64 0 0", k, wc[k], rc[k], er[k]);
            end
        end
    endtask

    task automatic test_byte_write();
        drive(1'b1, 4'hf, 32'h10, 32'h1122_3344);   step();
        drive(1'b1, 4'h5, 32'h10, 32'hAABB_CCDD);   step();
        drive(1'b1, 4'h0, 32'h10, 32'h0);           step();
        total++;
        if (rd[0] !== 32'h11BB_33DD || rv[0] !== 1'b1) begin
            bad++;
            $display("FAIL byte_write rdata=%h vld=%b required 11bb33dd 1", rd[0], rv[0]);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int n = 0; n < 3; n++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (rv[k] !== e_vld[k] || rd[k] !== e_rdata[k]) begin
                    bad++;
                    $display("FAIL byte_write_resp k=%0d vld=%b/%b rdata=%h/%h", k, rv[k], e_vld[k], rd[k], e_rdata[k]);
                end
            end
        end
        total++;
        if (rd[1] !== 32'h11BB_33DD) begin
            bad++;
            $display("FAIL byte_write_lat2 rdata=%h required 11bb33dd", rd[1]);
        end
    endtask

    task automatic test_read_first();
        drive(1'b1, 4'hf, 32'h20, 32'h5); step();
        drive(1'b1, 4'hf, 32'h20, 32'h9); step();
        total++;
        if (rv[0] !== 1'b0) begin
            bad++;
            $display("FAIL read_first_wvld vld=%b required 0", rv[0]);
        end
        drive(1'b1, 4'h0, 32'h20, 32'h0); step();
        total++;
        if (rd[0] !== 32'h9 || rv[0] !== 1'b1) begin
            bad++;
            $display("FAIL read_first rdata=%h vld=%b required 9 1", rd[0], rv[0]);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int n = 0; n < 3; n++) step();
    endtask

    task automatic test_streaming();
        logic [31:0] rc0;
        int          pulses;
        logic [31:0] want [3];
        rc0 = rc[2];
        for (int i = 0; i < 3; i++) want[i] = mm[2][i];
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            if (n < 3) drive(1'b1, 4'h0, 32'h80 + 32'(4 * n), 32'h0);
            else       drive(1'b0, 4'h0, 32'h0, 32'h0);
            step();
            total++;
            if (rv[2] !== ((n >= 2) && (n <= 4)) || rv[2] !== e_vld[2]) begin
                bad++;
                $display("FAIL stream_vld n=%0d vld=%b required %b", n, rv[2], (n >= 2) && (n <= 4));
            end
            if (n >= 2 && n <= 4) begin
                total++;
                if (rd[2] !== want[n-2]) begin
                    bad++;
                    $display("FAIL stream_data n=%0d rdata=%h required %h", n, rd[2], want[n-2]);
                end
                pulses++;
            end
        end
        total++;
        if (rc[2] - rc0 !== 32'd3 || pulses != 3) begin
            bad++;
            $display("FAIL stream_count delta=%0d required 3", rc[2] - rc0);
        end
    endtask

    task automatic test_range();
        drive(1'b1, 4'h0, 32'h40, 32'h0); step();
        total++;
        if (er[1] !== 1'b1 || er[0] !== 1'b0) begin
            bad++;
            $display("FAIL range_err err1=%b err0=%b required 1 0", er[1], er[0]);
        end
        drive(1'b1, 4'h0, 32'h44, 32'h0);
        err_clear = 1'b1;
        step();
        total++;
        if (er[1] !== 1'b1 || rv[1] !== 1'b1 || rd[1] !== 32'h0) begin
            bad++;
            $display("FAIL range_resp err=%b vld=%b rdata=%h required 1 1 0", er[1], rv[1], rd[1]);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        step();
        err_clear = 1'b0;
        total++;
        if (er[1] !== 1'b0 || rv[1] !== 1'b1 || rd[1] !== 32'h0) begin
            bad++;
            $display("FAIL range_clear err=%b vld=%b rdata=%h required 0 1 0", er[1], rv[1], rd[1]);
        end
        step();
    endtask

    task automatic test_idle();
        logic [31:0] rc_s [3];
        logic [31:0] wc_s [3];
        logic        er_s [3];
        for (int k = 0; k < 3; k++) begin rc_s[k] = rc[k]; wc_s[k] = wc[k]; er_s[k] = er[k]; end
        for (int n = 0; n < 6; n++) begin
            drive(1'b0, 4'hf, $urandom_range(0, 255), $urandom);
            err_clear = 1'b0;
            step();
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rc[k] !== rc_s[k] || wc[k] !== wc_s[k] || er[k] !== er_s[k] || rv[k] !== 1'b0) begin
                bad++;
                $display("FAIL idle_state k=%0d rc=%0d/%0d wc=%0d/%0d err=%b/%b vld=%b", k,
                         rc[k], rc_s[k], wc[k], wc_s[k], er[k], er_s[k], rv[k]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'h0, 32'h80 + 32'(i * 4), 32'h0);
            step();
            total++;
            if (rd[0] !== e_rdata[0] || rv[0] !== 1'b1) begin
                bad++;
                $display("FAIL idle_readback i=%0d rdata=%h required %h", i, rd[0], e_rdata[0]);
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int n = 0; n < 3; n++) step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 32'h11F));
            drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
                  a, $urandom);
            err_clear = ($urandom_range(0, 7) == 0);
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (rv[k] !== e_vld[k] || rd[k] !== e_rdata[k] || er[k] !== e_err[k] ||
                    rc[k] !== e_rd[k] || wc[k] !== e_wr[k]) begin
                    bad++;
                    $display("FAIL random n=%0d k=%0d vld=%b/%b rdata=%h/%h err=%b/%b rc=%0d/%0d wc=%0d/%0d",
                             n, k, rv[k], e_vld[k], rd[k], e_rdata[k], er[k], e_err[k],
                             rc[k], e_rd[k], wc[k], e_wr[k]);
                end
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        err_clear = 1'b0;
    endtask

    initial begin
        model_reset();
        #3 resetn = 1'b0;
        #20 resetn = 1'b1;
        test_reset();
        test_init();
        test_byte_write();
        test_read_first();
        test_streaming();
        test_range();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
